// File: rtl/rv32_bus_pkg.sv
// Shared types and bus widths for the instruction/data memory-bus arbiter.
package rv32_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic {IDLE, BUSY} rv32_bus_state_t;
    typedef enum logic {OWNER_INSTR, OWNER_DATA} rv32_bus_owner_t;

endpackage

// File: rtl/rv32_bus_arbiter_if.sv
// External memory bus seen by the arbiter (master) and the memory (slave).
interface rv32_bus_arbiter_if;
    import rv32_bus_pkg::*;

    logic              mem_valid_out;
    logic              mem_write_out;
    logic [ADDR_W-1:0] mem_address_out;
    logic [DATA_W-1:0] mem_write_value_out;
    logic [MASK_W-1:0] mem_write_mask_out;
    logic              mem_ready_in;
    logic [DATA_W-1:0] mem_read_value_in;

    modport master (
        output mem_valid_out, mem_write_out, mem_address_out,
               mem_write_value_out, mem_write_mask_out,
        input  mem_ready_in, mem_read_value_in
    );

    modport slave (
        input  mem_valid_out, mem_write_out, mem_address_out,
               mem_write_value_out, mem_write_mask_out,
        output mem_ready_in, mem_read_value_in
    );

endinterface

// File: rtl/rv32_bus_watchdog.sv
// Counts unacknowledged bus cycles and flags the last one before abort.
module rv32_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIMIT_I);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LIMIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A zero limit parameter disables the abort entirely
    assign timeout = (TIMEOUT_CYCLES != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between fetch and data ports; data has priority,
// bounded by a starvation limiter, with a watchdog abort on a silent bus.
//   state | meaning
//   IDLE  | no transaction outstanding; arbitrate current requests
//   BUSY  | mem_* request held until mem_ready_in or watchdog abort
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int MAX_DATA_GRANTS = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_read_in,
    input  logic [ADDR_W-1:0] instr_address_in,
    output logic              instr_ready_out,
    output logic              instr_error_out,
    output logic [DATA_W-1:0] instr_read_value_out,
    input  logic              data_read_in,
    input  logic              data_write_in,
    input  logic [ADDR_W-1:0] data_address_in,
    input  logic [DATA_W-1:0] data_write_value_in,
    input  logic [MASK_W-1:0] data_write_mask_in,
    output logic              data_ready_out,
    output logic              data_error_out,
    output logic [DATA_W-1:0] data_read_value_out,
    rv32_bus_arbiter_if.master mem
);

    localparam int SW = (MAX_DATA_GRANTS > 0) ? $clog2(MAX_DATA_GRANTS + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DATA_GRANTS);

    rv32_bus_state_t state;
    rv32_bus_owner_t owner;
    logic [SW-1:0]   starve_cnt;
    logic            data_req;
    logic            err_hold;
    logic            grant_data;
    logic            grant_instr;
    logic            timeout;

    assign data_req = data_read_in | data_write_in;
    // The cycle carrying an error pulse still sees the failed request held
    assign err_hold = instr_error_out | data_error_out;

    always_comb begin
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        if (state == IDLE && !err_hold) begin
            if (data_req && !(instr_read_in && starve_cnt == STARVE_MAX)) begin
                grant_data = 1'b1;
            end else if (instr_read_in) begin
                grant_instr = 1'b1;
            end
        end
    end

    rv32_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  ((state == BUSY) && !mem.mem_ready_in),
        .clear   (state == IDLE),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            owner                   <= OWNER_INSTR;
            starve_cnt              <= '0;
            instr_error_out         <= 1'b0;
            data_error_out          <= 1'b0;
            mem.mem_valid_out       <= 1'b0;
            mem.mem_write_out       <= 1'b0;
            mem.mem_address_out     <= '0;
            mem.mem_write_value_out <= '0;
            mem.mem_write_mask_out  <= '0;
        end else begin
            instr_error_out <= 1'b0;
            data_error_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state                   <= BUSY;
                        owner                   <= OWNER_DATA;
                        mem.mem_valid_out       <= 1'b1;
                        mem.mem_write_out       <= data_write_in;
                        mem.mem_address_out     <= data_address_in;
                        mem.mem_write_value_out <= data_write_value_in;
                        mem.mem_write_mask_out  <= data_write_in ? data_write_mask_in : '0;
                        if (!instr_read_in) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (grant_instr) begin
                        state                   <= BUSY;
                        owner                   <= OWNER_INSTR;
                        starve_cnt              <= '0;
                        mem.mem_valid_out       <= 1'b1;
                        mem.mem_write_out       <= 1'b0;
                        mem.mem_address_out     <= instr_address_in;
                        mem.mem_write_value_out <= '0;
                        mem.mem_write_mask_out  <= '0;
                    end
                end
                BUSY: begin
                    if (mem.mem_ready_in) begin
                        state             <= IDLE;
                        mem.mem_valid_out <= 1'b0;
                    end else if (timeout) begin
                        state             <= IDLE;
                        mem.mem_valid_out <= 1'b0;
                        instr_error_out   <= (owner == OWNER_INSTR);
                        data_error_out    <= (owner == OWNER_DATA);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is combinational so the owner sees data in the ready cycle
    assign instr_ready_out      = (state == BUSY) && (owner == OWNER_INSTR) && mem.mem_ready_in;
    assign data_ready_out       = (state == BUSY) && (owner == OWNER_DATA) && mem.mem_ready_in;
    assign instr_read_value_out = mem.mem_read_value_in;
    assign data_read_value_out  = mem.mem_read_value_in;

endmodule

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
- Shares one external memory bus between the instruction-fetch port and the data port driven by the memory stage.
- Data accesses have priority. A starvation limiter guarantees fetch progress.
- One transaction is outstanding at a time.
- A watchdog aborts accesses the bus never acknowledges and reports a bus error to the requester.

Parameters:
- MAX_DATA_GRANTS, 4: consecutive data grants allowed while a fetch is pending; after that, the fetch wins the next arbitration.
- TIMEOUT_CYCLES, 255: cycles in BUSY without mem_ready_in before abort. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instr_read_in  in  1  fetch request
- instr_address_in  in  32  fetch address
- instr_ready_out  out  1  one-cycle completion pulse to fetch
- instr_error_out  out  1  one-cycle timeout pulse to fetch
- instr_read_value_out  out  32  fetch data, valid with instr_ready_out
- data_read_in  in  1  load request
- data_write_in  in  1  store request
- data_address_in  in  32  load/store address
- data_write_value_in  in  32  store data
- data_write_mask_in  in  4  byte-lane enables for stores
- data_ready_out  out  1  one-cycle completion pulse to data port
- data_error_out  out  1  one-cycle timeout pulse to data port
- data_read_value_out  out  32  load data, valid with data_ready_out
- mem_valid_out  out  1  bus request valid
- mem_write_out  out  1  1 = write, 0 = read
- mem_address_out  out  32  bus address
- mem_write_value_out  out  32  bus write data
- mem_write_mask_out  out  4  bus byte mask; 0 for reads
- mem_ready_in  in  1  bus completion; read data valid in the same cycle
- mem_read_value_in  in  32  bus read data

Behaviour:
- Reset is asynchronous, active-low. Any assertion, including mid-transaction, forces:
  - state IDLE; mem_valid_out, mem_write_out, mem_write_mask_out = 0
  - mem_address_out, mem_write_value_out = 0
  - starvation and timeout counters = 0; no ready or error pulses
- Requesters hold the request and its operands stable until their ready or error pulse.
- A data request is data_read_in | data_write_in. If both are set, it is treated as a write.
- State IDLE: arbitrate on the current cycle's requests.
  - Neither request: stay in IDLE.
  - Only one requester: grant it.
  - Both requesters: grant data, unless starve_cnt == MAX_DATA_GRANTS, in which case grant fetch.
  - On a grant, register the granted source's address, write data, mask and direction into the mem_* outputs, set mem_valid_out = 1, set owner, clear the timeout counter, and go to BUSY.
  - For a fetch grant: mem_write_out = 0, mask = 0.
  - Latency: request seen in cycle N gives mem_valid_out = 1 in cycle N+1.
- State BUSY: mem_valid_out and the mem_* fields stay constant.
  - mem_ready_in = 1:
    - Combinationally pulse the owner's ready output for that cycle.
    - mem_read_value_in passes through to both *_read_value_out. The value is meaningful only to the owner.
    - Next cycle: mem_valid_out = 0, state IDLE.
    - This gives a one-cycle bubble between back-to-back transactions (intentional).
  - mem_ready_in = 0 with TIMEOUT_CYCLES != 0: increment the timeout counter.
    - When it reaches TIMEOUT_CYCLES - 1 and mem_ready_in is still 0, pulse the owner's error output (registered, next cycle), drop mem_valid_out, and return to IDLE.
    - A mem_ready_in arriving in the same cycle as the limit wins: normal completion, no error.
- Starvation counter, width $clog2(MAX_DATA_GRANTS+1), saturating:
  - Increments on each data grant made while instr_read_in = 1.
  - Clears on any fetch grant.
  - Clears on a data grant made with no fetch pending.
- A request withdrawn after its grant (e.g. fetch flushed by a taken branch) still completes on the bus. The ready pulse is still issued and the requester ignores it.
- A ready or error pulse never coincides with a new grant. The next grant occurs no earlier than the cycle after returning to IDLE.
- mem_ready_in while in IDLE is ignored.

Decomposition:
- Shared package rv32_bus_pkg holds:
  - typedef enum logic {IDLE, BUSY} rv32_bus_state_t
  - typedef enum logic {OWNER_INSTR, OWNER_DATA} rv32_bus_owner_t
  - bus width constants: address 32, data 32, mask 4
- Sub-module rv32_bus_watchdog: counter, enable, clear, timeout pulse; parameterised by TIMEOUT_CYCLES.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Fetch alone, addr 0x100, mem_ready_in after 2 cycles with 0xDEADBEEF -> mem_valid_out cycle 1, instr_ready_out pulse with instr_read_value_out = 0xDEADBEEF, data_ready_out = 0.
2. Simultaneous fetch 0x200 and store 0x8004, value 0x12345678, mask 4'b1100 -> data granted first with mem_write_out = 1, mask 4'b1100; fetch granted in the cycle after data completion returns to IDLE.
3. Fetch held pending while data issues continuous requests, MAX_DATA_GRANTS = 4, bus ready every cycle -> exactly 4 data grants, then a fetch grant, then data resumes.
4. TIMEOUT_CYCLES = 8, load with mem_ready_in held 0 -> data_error_out pulse 8 cycles after grant, mem_valid_out drops, no data_ready_out; next request is granted normally.
5. reset_n asserted in BUSY mid-store -> all outputs 0 immediately (asynchronous), state IDLE, starve_cnt 0; after release, a pending fetch is granted cleanly.
6. Fetch withdrawn one cycle after its grant -> bus transaction completes, instr_ready_out still pulses, no error.
